// File: rtl/npc_ctrl.sv
// Fetch-stage next-PC sequencer: owns the PC, selects sequential/branch/jump/register
// targets and parks a redirect that arrives during a stall. Option: NPC_ALIGN_CHECK_EN.
module npc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] d_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pend,
    output logic        err_align
);

    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pend_tgt_reg;
    logic        redirect_pend_reg;

    logic [31:0] d_pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] rq_tgt;
    logic        rq;

    assign d_pc_plus4 = d_pc + 32'd4;
    // Shifting the whole offset left by two equals appending 2'b00 to bits [29:0].
    assign br_tgt     = d_pc_plus4 + (br_offset << 2);
    assign j_tgt      = {d_pc_plus4[31:28], j_index, 2'b00};

`ifdef NPC_ALIGN_CHECK_EN
    logic rq_mis;
    logic pend_mis_reg;
    logic err_align_reg;

    assign jr_tgt    = jr_target & 32'hFFFF_FFFC;
    assign rq_mis    = jr_valid & (jr_target[1:0] != 2'b00);
    assign err_align = err_align_reg;
`else
    assign jr_tgt    = jr_target;
    assign err_align = 1'b0;
`endif

    assign rq     = jr_valid | j_valid | (br_valid & br_taken);
    assign rq_tgt = jr_valid ? jr_tgt : (j_valid ? j_tgt : br_tgt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= RUN;
            pc_reg            <= RESET_PC;
            pend_tgt_reg      <= 32'd0;
            redirect_pend_reg <= 1'b0;
`ifdef NPC_ALIGN_CHECK_EN
            pend_mis_reg      <= 1'b0;
            err_align_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                RUN, HOLD: begin
                    if (!stall) begin
                        pc_reg    <= rq ? rq_tgt : pc_reg + 32'd4;
                        state_reg <= RUN;
`ifdef NPC_ALIGN_CHECK_EN
                        if (rq && rq_mis)
                            err_align_reg <= 1'b1;
`endif
                    end else if (rq) begin
                        pend_tgt_reg      <= rq_tgt;
                        redirect_pend_reg <= 1'b1;
                        state_reg         <= HOLD_PEND;
`ifdef NPC_ALIGN_CHECK_EN
                        pend_mis_reg      <= rq_mis;
`endif
                    end else begin
                        state_reg <= HOLD;
                    end
                end
                HOLD_PEND: begin
                    // The frozen decode instruction re-presents its request; only the parked copy counts.
                    if (!stall) begin
                        pc_reg            <= pend_tgt_reg;
                        redirect_pend_reg <= 1'b0;
                        state_reg         <= RUN;
`ifdef NPC_ALIGN_CHECK_EN
                        if (pend_mis_reg)
                            err_align_reg <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg         <= RUN;
                    redirect_pend_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + 32'd4;
    assign redirect_pend = redirect_pend_reg;

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: directed vector table, hand-written stall sequences,
// then random stimulus against a queue-based reference model.
module tb_npc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef NPC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] d_pc;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        j_valid;
    logic [25:0] j_index;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_pend;
    logic        err_align;

    npc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .d_pc(d_pc),
        .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
        .j_valid(j_valid), .j_index(j_index), .jr_valid(jr_valid), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .redirect_pend(redirect_pend), .err_align(err_align)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the PC, an at-most-one-deep queue of parked {misaligned, target}, sticky error.
    logic [31:0] m_pc;
    logic [32:0] m_q[$];
    logic        m_err;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [31:0] dpc;
        logic        bv;
        logic        bt;
        logic [31:0] bo;
        logic        jv;
        logic [25:0] ji;
        logic        jrv;
        logic [31:0] jrt;
        logic [31:0] epc;
        logic        epend;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic [31:0] dpc, logic bv, logic bt,
                                logic [31:0] bo, logic jv, logic [25:0] ji, logic jrv,
                                logic [31:0] jrt, logic [31:0] epc, logic epend, logic eerr);
        vec_t v;
        v.rst = rst; v.stl = stl; v.dpc = dpc; v.bv = bv; v.bt = bt; v.bo = bo;
        v.jv = jv; v.ji = ji; v.jrv = jrv; v.jrt = jrt;
        v.epc = epc; v.epend = epend; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_target();
        logic [31:0] seq4;
        seq4 = d_pc + 32'd4;
        if (jr_valid)
            return ALIGN ? (jr_target & 32'hFFFF_FFFC) : jr_target;
        if (j_valid)
            return (seq4 & 32'hF000_0000) | ({6'd0, j_index} * 32'd4);
        return seq4 + br_offset * 32'd4;
    endfunction

    task automatic model_step();
        logic        rq;
        logic        mis;
        logic [32:0] e;
        rq  = jr_valid | j_valid | (br_valid & br_taken);
        mis = ALIGN & jr_valid & (jr_target[1:0] != 2'b00);
        if (reset) begin
            m_pc  = RST_PC;
            m_q.delete();
            m_err = 1'b0;
        end else if (m_q.size() != 0) begin
            if (!stall) begin
                e    = m_q.pop_front();
                m_pc = e[31:0];
                if (e[32]) m_err = 1'b1;
            end
        end else if (!stall) begin
            if (rq) begin
                m_pc = ref_target();
                if (mis) m_err = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (rq) begin
            m_q.push_back({mis, ref_target()});
        end
    endtask

    task automatic apply(input logic rst, input logic stl, input logic [31:0] dpc, input logic bv,
                         input logic bt, input logic [31:0] bo, input logic jv,
                         input logic [25:0] ji, input logic jrv, input logic [31:0] jrt);
        reset = rst; stall = stl; d_pc = dpc; br_valid = bv; br_taken = bt; br_offset = bo;
        j_valid = jv; j_index = ji; jr_valid = jrv; jr_target = jrt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] epc, input logic epend,
                             input logic eerr);
        $display("%s rst=%0d stall=%0d br=%0d%0d j=%0d jr=%0d -> pc=%h pend=%0d err=%0d",
                 tag, reset, stall, br_valid, br_taken, j_valid, jr_valid, pc, redirect_pend, err_align);
        check({tag, " pc"}, pc, epc);
        check({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
        check({tag, " redirect_pend"}, {31'd0, redirect_pend}, {31'd0, epend});
        check({tag, " err_align"}, {31'd0, err_align}, {31'd0, eerr});
    endtask

    initial begin
        logic [31:0] pc3006;
        logic [31:0] r;
        vec_t        v;
        pc3006 = ALIGN ? 32'h0000_3004 : 32'h0000_3006;
        m_pc   = RST_PC;
        m_err  = 1'b0;

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 32'h3000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3010, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h3004, 0, 0));
        vecs.push_back(mk(0, 0, 32'h3010, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h3008, 0, 0));
        vecs.push_back(mk(0, 1, 32'h3004, 0, 0, 0, 1, 26'h0000C10, 0, 0, 32'h3008, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3004, 0, 0, 0, 1, 26'h0000C10, 0, 0, 32'h3008, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3004, 0, 0, 0, 1, 26'h0000C10, 0, 0, 32'h3008, 1, 0));
        vecs.push_back(mk(0, 0, 32'h3004, 0, 0, 0, 1, 26'h0000C10, 0, 0, 32'h3040, 0, 0));
        vecs.push_back(mk(0, 0, 32'h301C, 1, 1, 32'h0, 0, 0, 1, 32'h4000, 32'h4000, 0, 0));
        vecs.push_back(mk(0, 0, 32'hFFFF_FFF8, 1, 1, 32'h1, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3006, pc3006, 0, ALIGN));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h5000, pc3006, 1, ALIGN));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h5000, 32'h3000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v.rst, v.stl, v.dpc, v.bv, v.bt, v.bo, v.jv, v.ji, v.jrv, v.jrt);
            check_out($sformatf("vec%0d", i), v.epc, v.epend, v.eerr);
        end

        // HOLD -> HOLD_PEND, then a different request at release must not win.
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("seq_hold1", 32'h3004, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("seq_hold2", 32'h3004, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h7000);
        check_out("seq_capture", 32'h3004, 1, 0);
        apply(0, 1, 0, 0, 0, 0, 1, 26'h100, 0, 0);
        check_out("seq_ignore", 32'h3004, 1, 0);
        apply(0, 0, 32'h3000, 1, 1, 32'h8, 0, 0, 0, 0);
        check_out("seq_release", 32'h7000, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("seq_seq", 32'h7004, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("seq_hold3", 32'h7004, 0, 0);
        apply(0, 0, 32'h7000, 1, 1, 32'h2, 0, 0, 0, 0);
        check_out("seq_hold_br", 32'h700C, 0, 0);

        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("rnd_reset", m_pc, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 4) < 2,
                  (i % 7 == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : (r & 32'hFFFF_FFFC),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  {{16{r[31]}}, r[31:16]}, $urandom_range(0, 3) == 0, 26'($urandom),
                  $urandom_range(0, 4) == 0, $urandom);
            check_out($sformatf("rnd%0d", i), m_pc, m_q.size() != 0, m_err);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Fetch-stage next-PC sequencer for the P6 pipelined MIPS core. It owns the PC register and decides each cycle between sequential fetch, a branch target computed from the decode-stage PC plus the shifted offset, a `j`/`jal` pseudo-direct target, and a `jr`/`jalr` register target. It holds the PC through pipeline stalls and remembers any redirect that arrives during a stall, so no control transfer is lost. It sits between the decode-stage branch comparator and the instruction memory address port.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard-unit freeze of the F and D stages.
- `d_pc`  in  32: PC of the instruction currently in decode.
- `br_valid`  in  1: decode holds a conditional branch.
- `br_taken`  in  1: branch comparison result; qualified by `br_valid`.
- `br_offset`  in  32: sign-extended 16-bit immediate, unshifted.
- `j_valid`  in  1: decode holds `j`/`jal`.
- `j_index`  in  26: instr_index field.
- `jr_valid`  in  1: decode holds `jr`/`jalr`.
- `jr_target`  in  32: forwarded rs value.
- `pc`  out  32: fetch address (registered).
- `pc_plus4`  out  32: `pc + 4`, combinational.
- `redirect_pend`  out  1: a captured redirect is waiting for the stall to release.
- `err_align`  out  1: sticky misaligned-`jr` flag (see Configuration).

## Operation
- Target arithmetic is modulo 2^32, and every wrap is silent:
  - branch target = `d_pc + 4 + {br_offset[29:0],2'b00}`
  - jump target = `{d_pc_plus4[31:28], j_index, 2'b00}`, where `d_pc_plus4 = d_pc + 4`
  - register target = `jr_target`
- Redirect request `rq` = `jr_valid | j_valid | (br_valid & br_taken)`.
- Priority when several are valid at once: jr > j > br. A not-taken branch produces no request.
- Delay-slot semantics: no flush is generated. The slot instruction is already in F and completes normally.
- State machine with states RUN, HOLD, HOLD_PEND:
  - RUN, `stall`=0: `pc` <= target if `rq`, else `pc + 4`. Stay in RUN.
  - RUN, `stall`=1, `rq`=0: `pc` held. Go to HOLD.
  - RUN, `stall`=1, `rq`=1: `pc` held. Target captured in `pend_tgt`. Go to HOLD_PEND.
  - HOLD, `stall`=1: `pc` held. If `rq`, capture the target and go to HOLD_PEND.
  - HOLD, `stall`=0: behaves exactly as RUN with `stall`=0. Go to RUN.
  - HOLD_PEND, `stall`=1: `pc` held. New `rq` is ignored, because the decode instruction is frozen and re-presents the same request.
  - HOLD_PEND, `stall`=0: `pc` <= `pend_tgt`, even if `rq` is asserted this cycle (it is the same request). Go to RUN.
- `redirect_pend` = 1 exactly while in HOLD_PEND.
- Reset (at any state, including HOLD_PEND): `pc`=`RESET_PC`, state RUN, `pend_tgt`=0, `redirect_pend`=0, `err_align`=0.
- Reset values as seen at the outputs: `pc_plus4` = `RESET_PC`+4. Reset overrides `stall` and all requests in the same cycle.

## Timing
- All state updates happen on the rising edge of `clk`.
- Redirect latency: a request sampled with `stall`=0 in cycle N makes `pc` equal the target in cycle N+1.
- Redirect under stall: if the request is captured in cycle N and `stall` falls in cycle M, `pc` equals the target in cycle M+1.
- `pc_plus4` is combinational from `pc`, with zero latency.
- `err_align` rises in the cycle after the offending target is loaded into `pc`.
- No input is registered inside the block. `stall` and the request inputs must be stable before the edge.

## Configuration
- Macro `NPC_ALIGN_CHECK_EN`, when defined:
  - A `jr` target with `jr_target[1:0]` != 0 is loaded with bits [1:0] forced to 00.
  - `err_align` is set and stays set until `reset`.
  - The check applies whether the target is loaded directly or from `pend_tgt`.
- When the macro is undefined:
  - `jr_target` is loaded unmodified.
  - `err_align` is tied to 0.
  - No alignment logic is synthesized.

## Test plan
- Reset and sequential fetch: assert `reset` for 2 cycles, then release with no requests -> `pc` = 0x3000, 0x3004, 0x3008 on successive cycles; `pc_plus4` = 0x3004 at reset.
- Taken backward branch: `d_pc`=0x3010, `br_offset`=32'hFFFF_FFFC, taken, `stall`=0 -> next `pc` = 0x3004. Same stimulus with `br_taken`=0 -> `pc` advances by 4.
- Redirect during stall: `j_valid` with `j_index`=26'h0000C10 while `stall`=1 for 3 cycles, request held throughout -> `pc` frozen and `redirect_pend`=1 for those cycles; one cycle after `stall` falls, `pc` = 0x0000_3040 and `redirect_pend`=0.
- Simultaneous requests: `jr_valid` with `jr_target`=0x0000_4000 together with a taken branch to 0x3020 -> `pc` = 0x4000.
- Wrap-around: `d_pc`=0xFFFF_FFF8, `br_offset`=1, taken -> `pc` = 0x0000_0000; `pc`=0xFFFF_FFFC with no request -> `pc` = 0x0000_0000.
- Alignment and reset in HOLD_PEND:
  - `jr_target`=0x0000_3006 -> with `NPC_ALIGN_CHECK_EN`, `pc`=0x3004 and `err_align`=1; without it, `pc`=0x3006 and `err_align`=0.
  - Assert `reset` while in HOLD_PEND -> `pc`=0x3000, `redirect_pend`=0, and the pending target is dropped.
